// File: rtl/mac_inserter_pkg.sv
// rtl/mac_inserter_pkg.sv - shared widths, insertion state enum and last-word helper
package mac_pkg;
    localparam int MAC_W  = 48;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2
    } state_t;

    // The word produced in this state carries the final MAC byte.
    function automatic logic is_last_word(input state_t st, input logic [1:0] off);
        return ((st == W1) && (off != 2'd3)) || (st == W2);
    endfunction
endpackage

// File: rtl/mac_inserter_if.sv
// rtl/mac_inserter_if.sv - stream and control bundle; mac_lanes present when MAC_LANE_MASK_EN is defined
interface mac_inserter_if;
    logic                       clear;
    logic                       start;
    logic [1:0]                 offset;
    logic [mac_pkg::MAC_W-1:0]  flagged_mac;
    logic [mac_pkg::DATA_W-1:0] data_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [mac_pkg::DATA_W-1:0] data_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       done;
`ifdef MAC_LANE_MASK_EN
    logic [3:0]                 mac_lanes;
`endif

    modport slave (
        input  clear, start, offset, flagged_mac, data_in, in_valid, out_ready,
        output in_ready, data_out, out_valid,
`ifdef MAC_LANE_MASK_EN
        output mac_lanes,
`endif
        output done
    );

    modport master (
        output clear, start, offset, flagged_mac, data_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid,
`ifdef MAC_LANE_MASK_EN
        input  mac_lanes,
`endif
        input  done
    );
endinterface

// File: rtl/mac_inserter_lane_mux.sv
// rtl/mac_inserter_lane_mux.sv - combinational big-endian MAC byte overlay for one word
module mac_lane_mux
    import mac_pkg::*;
(
    input  state_t              state,
    input  logic [1:0]          offset,
    input  logic [MAC_W-1:0]    mac,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic [3:0]          lanes
);
    // IDLE here means "first MAC word"; the caller decides whether insertion is active.
    always_comb begin
        data_out = data_in;
        lanes    = 4'b0000;
        case (state)
            IDLE: begin
                case (offset)
                    2'd0: begin data_out = mac[47:16];                   lanes = 4'b1111; end
                    2'd1: begin data_out = {data_in[31:24], mac[47:24]}; lanes = 4'b0111; end
                    2'd2: begin data_out = {data_in[31:16], mac[47:32]}; lanes = 4'b0011; end
                    2'd3: begin data_out = {data_in[31:8],  mac[47:40]}; lanes = 4'b0001; end
                endcase
            end
            W1: begin
                case (offset)
                    2'd0: begin data_out = {mac[15:0], data_in[15:0]};   lanes = 4'b1100; end
                    2'd1: begin data_out = {mac[23:0], data_in[7:0]};    lanes = 4'b1110; end
                    2'd2: begin data_out = mac[31:0];                    lanes = 4'b1111; end
                    2'd3: begin data_out = mac[39:8];                    lanes = 4'b1111; end
                endcase
            end
            W2: begin
                if (offset == 2'd3) begin
                    data_out = {mac[7:0], data_in[23:0]};
                    lanes    = 4'b1000;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mac_inserter.sv
// rtl/mac_inserter.sv - overwrites a 48-bit MAC into a 32-bit word stream; optional MAC_LANE_MASK_EN lane mask
module mac_inserter
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mac_inserter_if.slave    bus
);
    state_t              state;
    logic [MAC_W-1:0]    mac_q;
    logic [1:0]          off_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                done_q;
    logic                accept;
    logic                begin_ins;
    logic                inserting;
    logic [1:0]          mux_off;
    logic [MAC_W-1:0]    mux_mac;
    logic [DATA_W-1:0]   mux_data;
    logic [3:0]          mux_lanes;

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign begin_ins     = (state == IDLE) && bus.start;
    assign inserting     = begin_ins || (state != IDLE);
    // The first word uses the live MAC/offset; later words use the latched copy.
    assign mux_off       = (state == IDLE) ? bus.offset      : off_q;
    assign mux_mac       = (state == IDLE) ? bus.flagged_mac : mac_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.done      = done_q;

    mac_lane_mux u_mux (
        .state    (state),
        .offset   (mux_off),
        .mac      (mux_mac),
        .data_in  (bus.data_in),
        .data_out (mux_data),
        .lanes    (mux_lanes)
    );

    // Insertion FSM and MAC/offset latch; advances only on accepted words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mac_q <= '0;
            off_q <= 2'd0;
        end else if (bus.clear) begin
            state <= IDLE;
        end else if (accept) begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= W1;
                    mac_q <= bus.flagged_mac;
                    off_q <= bus.offset;
                end
                W1:      state <= (off_q == 2'd3) ? W2 : IDLE;
                W2:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One-stage output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.clear) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept) begin
            data_q  <= inserting ? mux_data : bus.data_in;
            valid_q <= 1'b1;
            done_q  <= inserting && is_last_word(state, mux_off);
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

`ifdef MAC_LANE_MASK_EN
    logic [3:0] lanes_q;
    assign bus.mac_lanes = lanes_q;

    // Lane mask registered alongside data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= 4'b0000;
        end else if (!bus.clear && accept) begin
            lanes_q <= inserting ? mux_lanes : 4'b0000;
        end
    end
`else
    logic unused_lanes;
    assign unused_lanes = ^mux_lanes;
`endif
endmodule
